// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared state encoding and limits for the adder response checker
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_PIPE_LAT = 7;

endpackage

// File: rtl/stim_delay_line.sv
// rtl/stim_delay_line.sv - valid/data shift register aligning applied vectors with DUT responses
module stim_delay_line #(
    parameter int W     = 3,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = clear ^ clk ^ rst_n;
            assign out_valid   = in_valid;
            assign out_data    = in_data;
        end else begin : g_shift
            logic [DEPTH-1:0] valid_sr;
            logic [W-1:0]     data_sr [DEPTH];

            // Only the valid bits need clearing; stale data behind a 0 valid is never used.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_sr <= '0;
                end else if (clear) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr[0] <= in_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_sr[i] <= valid_sr[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                data_sr[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    data_sr[i] <= data_sr[i-1];
                end
            end

            assign out_valid = valid_sr[DEPTH-1];
            assign out_data  = data_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/adder_response_checker.sv
// rtl/adder_response_checker.sv - golden-model response checker for an adder under test
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int PIPE_LAT = 0,
    parameter int NUM_VEC  = 8,
    parameter int ERR_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           vec_valid,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic                           c_in,
    input  logic [WIDTH-1:0]               dut_sum,
    input  logic                           dut_c_out,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [$clog2(NUM_VEC+1)-1:0]   vec_count,
    output logic [ERR_W-1:0]               err_count,
    output logic [2*WIDTH:0]               first_err
);

    localparam int VW = 2*WIDTH + 1;
    localparam int CW = $clog2(NUM_VEC+1);
    localparam logic [CW-1:0] NUM_VEC_C = CW'(NUM_VEC);
    localparam logic [CW-1:0] LAST_C    = CW'(NUM_VEC - 1);

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  issue_count;
    logic           run_start;
    logic           capture;
    logic           d_valid;
    logic [VW-1:0]  d_vec;
    logic [WIDTH-1:0] d_a;
    logic [WIDTH-1:0] d_b;
    logic           d_c;
    logic [WIDTH:0] golden;
    logic           compare;
    logic           mismatch;

    assign run_start = start && (state != RUN);
    // Issued count caps capture so surplus vectors never enter the delay line.
    assign capture   = (state == RUN) && vec_valid && (issue_count < NUM_VEC_C);

    stim_delay_line #(
        .W     (VW),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (run_start),
        .in_valid  (capture),
        .in_data   ({a, b, c_in}),
        .out_valid (d_valid),
        .out_data  (d_vec)
    );

    assign d_a      = d_vec[VW-1:WIDTH+1];
    assign d_b      = d_vec[WIDTH:1];
    assign d_c      = d_vec[0];
    assign golden   = {1'b0, d_a} + {1'b0, d_b} + {{WIDTH{1'b0}}, d_c};
    assign compare  = d_valid && (state == RUN);
    // Case inequality so an X/Z response is scored as a failure.
    assign mismatch = ({dut_c_out, dut_sum} !== golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (compare && (vec_count == LAST_C)) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= '0;
            vec_count   <= '0;
            err_count   <= '0;
            first_err   <= '0;
        end else if (run_start) begin
            issue_count <= '0;
            vec_count   <= '0;
            err_count   <= '0;
            first_err   <= '0;
        end else begin
            if (capture) begin
                issue_count <= issue_count + 1'b1;
            end
            if (compare) begin
                vec_count <= vec_count + 1'b1;
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (err_count == '0) begin
                        first_err <= d_vec;
                    end
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_adder_response_checker.sv
// tb/tb_adder_response_checker.sv - directed bench for adder_response_checker
module tb_adder_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, vec_valid, a, b, c_in;
    logic inject_one, bad_all;

    logic fa_s, fa_c, s0;
    logic [1:0] r1, r2;
    assign fa_s = a ^ b ^ c_in;
    assign fa_c = (a & b) | (a & c_in) | (b & c_in);

    always_comb begin
        s0 = fa_s;
        if (bad_all) s0 = ~fa_s;
        if (inject_one && ({a, b, c_in} == 3'b101)) s0 = ~fa_s;
    end

    always @(posedge clk) begin
        r1 <= {fa_c, fa_s};
        r2 <= r1;
    end

    logic       busy0, done0, pass0;
    logic [3:0] vc0;
    logic [7:0] ec0;
    logic [2:0] fe0;
    logic       busy1, done1, pass1;
    logic [3:0] vc1;
    logic [7:0] ec1;
    logic [2:0] fe1;
    logic       busy2, done2, pass2;
    logic [3:0] vc2;
    logic [7:0] ec2;
    logic [2:0] fe2;
    logic       busye, donee, passe;
    logic [3:0] vce;
    logic [1:0] ece;
    logic [2:0] fee;

    adder_response_checker #(.WIDTH(1), .PIPE_LAT(0), .NUM_VEC(8), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .a(a), .b(b), .c_in(c_in), .dut_sum(s0), .dut_c_out(fa_c),
        .busy(busy0), .done(done0), .pass(pass0),
        .vec_count(vc0), .err_count(ec0), .first_err(fe0));

    adder_response_checker #(.WIDTH(1), .PIPE_LAT(1), .NUM_VEC(8), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .a(a), .b(b), .c_in(c_in), .dut_sum(r2[0]), .dut_c_out(r2[1]),
        .busy(busy1), .done(done1), .pass(pass1),
        .vec_count(vc1), .err_count(ec1), .first_err(fe1));

    adder_response_checker #(.WIDTH(1), .PIPE_LAT(2), .NUM_VEC(8), .ERR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .a(a), .b(b), .c_in(c_in), .dut_sum(r2[0]), .dut_c_out(r2[1]),
        .busy(busy2), .done(done2), .pass(pass2),
        .vec_count(vc2), .err_count(ec2), .first_err(fe2));

    adder_response_checker #(.WIDTH(1), .PIPE_LAT(0), .NUM_VEC(8), .ERR_W(2)) ue (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .a(a), .b(b), .c_in(c_in), .dut_sum(1'b0), .dut_c_out(1'b0),
        .busy(busye), .done(donee), .pass(passe),
        .vec_count(vce), .err_count(ece), .first_err(fee));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_vectors(input int first, input int n);
        logic [2:0] v;
        for (int i = 0; i < n; i++) begin
            v = 3'(first + i);
            {a, b, c_in} = v;
            vec_valid = 1'b1;
            step();
        end
        vec_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done0 && cyc < 20) begin
            step();
            cyc++;
        end
        n_checks++;
        if (done0 !== 1'b1) begin n_fail++; $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done0, cyc); end
        repeat (3) step();
    endtask

    task automatic run_full();
        pulse_start();
        send_vectors(0, 8);
        wait_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done0); end
        n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %b want 0", pass0); end
        n_checks++; if (vc0 !== 4'd0) begin n_fail++; $display("FAIL rst_vec_count: got %0d want 0", vc0); end
        n_checks++; if (ec0 !== 8'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d want 0", ec0); end
        n_checks++; if (fe0 !== 3'b000) begin n_fail++; $display("FAIL rst_first_err: got %b want 000", fe0); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exhaustive();
        pulse_start();
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL exh_busy: got %b want 1", busy0); end
        send_vectors(0, 8);
        wait_done();
        n_checks++; if (vc0 !== 4'd8) begin n_fail++; $display("FAIL exh_vec_count: got %0d want 8", vc0); end
        n_checks++; if (ec0 !== 8'd0) begin n_fail++; $display("FAIL exh_err_count: got %0d want 0", ec0); end
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL exh_pass: got %b want 1", pass0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL exh_busy_end: got %b want 0", busy0); end
    endtask

    task automatic test_single_error();
        inject_one = 1'b1;
        run_full();
        inject_one = 1'b0;
        n_checks++; if (ec0 !== 8'd1) begin n_fail++; $display("FAIL single_err_count: got %0d want 1", ec0); end
        n_checks++; if (fe0 !== 3'b101) begin n_fail++; $display("FAIL single_first_err: got %b want 101", fe0); end
        n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL single_pass: got %b want 0", pass0); end
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done0); end
    endtask

    task automatic test_pipe_latency();
        run_full();
        n_checks++; if (pass2 !== 1'b1) begin n_fail++; $display("FAIL lat2_pass: got %b want 1", pass2); end
        n_checks++; if (vc2 !== 4'd8) begin n_fail++; $display("FAIL lat2_vec_count: got %0d want 8", vc2); end
        n_checks++; if (ec1 == 8'd0) begin n_fail++; $display("FAIL lat1_err_count: got %0d want >0", ec1); end
        n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL lat1_pass: got %b want 0", pass1); end
    endtask

    task automatic test_saturation();
        run_full();
        n_checks++; if (ece !== 2'd3) begin n_fail++; $display("FAIL sat_err_count: got %0d want 3", ece); end
        n_checks++; if (fee !== 3'b001) begin n_fail++; $display("FAIL sat_first_err: got %b want 001", fee); end
        n_checks++; if (vce !== 4'd8) begin n_fail++; $display("FAIL sat_vec_count: got %0d want 8", vce); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        send_vectors(0, 4);
        n_checks++; if (vc0 !== 4'd4) begin n_fail++; $display("FAIL mid_vec_count_pre: got %0d want 4", vc0); end
        n_checks++; if (ece !== 2'd3) begin n_fail++; $display("FAIL mid_sat_pre: got %0d want 3", ece); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy0); end
        n_checks++; if (vc0 !== 4'd0) begin n_fail++; $display("FAIL mid_rst_vec_count: got %0d want 0", vc0); end
        n_checks++; if (ece !== 2'd0) begin n_fail++; $display("FAIL mid_rst_err_count: got %0d want 0", ece); end
        n_checks++; if (fee !== 3'b000) begin n_fail++; $display("FAIL mid_rst_first_err: got %b want 000", fee); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", done0); end
        step();
        rst_n = 1'b1;
        step();
        run_full();
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_pass: got %b want 1", pass0); end
        n_checks++; if (vc0 !== 4'd8) begin n_fail++; $display("FAIL mid_rerun_vec_count: got %0d want 8", vc0); end
    endtask

    task automatic test_start_in_run();
        pulse_start();
        send_vectors(0, 3);
        {a, b, c_in} = 3'd3;
        vec_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        send_vectors(4, 4);
        bad_all = 1'b1;
        send_vectors(8, 4);
        bad_all = 1'b0;
        wait_done();
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL sir_done: got %b want 1", done0); end
        n_checks++; if (vc0 !== 4'd8) begin n_fail++; $display("FAIL sir_vec_count: got %0d want 8", vc0); end
        n_checks++; if (ec0 !== 8'd0) begin n_fail++; $display("FAIL sir_err_count: got %0d want 0", ec0); end
        bad_all = 1'b1;
        send_vectors(0, 3);
        bad_all = 1'b0;
        n_checks++; if (vc0 !== 4'd8) begin n_fail++; $display("FAIL idle_drop_vec_count: got %0d want 8", vc0); end
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL idle_drop_pass: got %b want 1", pass0); end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        vec_valid  = 1'b0;
        a          = 1'b0;
        b          = 1'b0;
        c_in       = 1'b0;
        inject_one = 1'b0;
        bad_all    = 1'b0;
        test_reset();
        test_exhaustive();
        test_single_error();
        test_pipe_latency();
        test_saturation();
        test_reset_mid_run();
        test_start_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
